// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: decodes a scanned active-low 4-digit 7-segment bus (iSEG/iAN) back into oDIG with oFRAME/oERR/oVALID status
module seg7_scan_capture #(
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [6:0]  iSEG,
    input  logic [3:0]  iAN,
    output logic [15:0] oDIG,
    output logic        oFRAME,
    output logic        oERR,
    output logic        oVALID
);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [3:0]    an, nib, seen, seen_nxt;
    logic [1:0]    k, prev_k;
    logic [6:0]    prev_seg;
    logic          blank, prev_blank, eq, cap, ok, full, pend;
    logic [CW-1:0] scnt, scnt_nxt;
    logic [TW-1:0] tcnt;

    always_comb begin
        an       = ~iAN;
        blank    = an == 4'd0 || (an & (an - 4'd1)) != 4'd0;
        k        = {an[3] | an[2], an[3] | an[1]};
        eq       = !blank && !prev_blank && k == prev_k && iSEG == prev_seg;
        scnt_nxt = blank ? '0 : !eq ? CW'(1) : scnt == CW'(STABLE_CNT) ? scnt : scnt + CW'(1);
        cap      = !blank && (eq ? scnt == CW'(STABLE_CNT - 1) : STABLE_CNT == 1);
        seen_nxt = seen | (4'd1 << k);
        full     = seen_nxt == 4'hF;
    end

    always_comb begin
        ok  = 1'b1;
        nib = 4'h0;
        case (iSEG)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0011000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            default:    ok  = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDIG       <= '0;
            oFRAME     <= 1'b0;
            oERR       <= 1'b0;
            oVALID     <= 1'b0;
            seen       <= '0;
            pend       <= 1'b0;
            scnt       <= '0;
            tcnt       <= '0;
            prev_k     <= '0;
            prev_seg   <= '0;
            prev_blank <= 1'b1;
        end else begin
            prev_k     <= k;
            prev_seg   <= iSEG;
            prev_blank <= blank;
            scnt       <= scnt_nxt;
            oFRAME     <= 1'b0;
            if (cap) begin
                if (ok)
                    oDIG[{k, 2'b00} +: 4] <= nib;
                tcnt <= '0;
                if (full) begin
                    oFRAME <= 1'b1;
                    oERR   <= pend | ~ok;
                    oVALID <= 1'b1;
                    seen   <= '0;
                    pend   <= 1'b0;
                end else begin
                    seen <= seen_nxt;
                    pend <= pend | ~ok;
                end
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
                oVALID <= 1'b0;
                seen   <= '0;
                pend   <= 1'b0;
                tcnt   <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: scoreboard bench for seg7_scan_capture with directed scans, glitches, faults, timeout and reset
module tb_seg7_scan_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = '1;
    logic [3:0]  an = '1;
    logic [15:0] dig;
    logic        frame, err, valid;
    int          checks = 0, errors = 0, frames = 0, nexp = 0;
    logic [16:0] q[$];
    logic [6:0]  tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    seg7_scan_capture #(.STABLE_CNT(4), .TIMEOUT(100)) dut (
        .iCLK(clk), .iRST(rst), .iSEG(seg), .iAN(an),
        .oDIG(dig), .oFRAME(frame), .oERR(err), .oVALID(valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input int d, input logic [6:0] p, input int n);
        an  = ~(4'b0001 << d);
        seg = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        an = '1;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [16:0] e);
        q.push_back(e);
        nexp++;
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                        input logic [6:0] p3, input logic [16:0] e);
        put(0, p0, 8);
        put(1, p1, 8);
        put(2, p2, 8);
        expect_frame(e);
        an  = 4'b0111;
        seg = p3;
        repeat (4) @(negedge clk);
        chk("frame_pulse", frame, 1);
        @(negedge clk);
        chk("frame_single", frame, 0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (frame) begin
            frames++;
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_frame got dig %0h expected no frame", dig);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("frame_dig", dig, e[15:0]);
                chk("frame_err", err, e[16]);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dig", dig, 0);
        chk("rst_frame", frame, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", valid, 0);
        rst = 1'b0;
        scan(tbl[4], tbl[3], tbl[2], tbl[1], {1'b0, 16'h1234});
        chk("scan_dig", dig, 16'h1234);
        chk("scan_err", err, 0);
        chk("scan_valid", valid, 1);
        put(1, tbl[8], 3);
        idle(2);
        chk("glitch_dig", dig, 16'h1234);
        chk("glitch_frames", frames, 1);
        scan(tbl[8], tbl[7], 7'h7F, tbl[5], {1'b1, 16'h5278});
        chk("inv_err", err, 1);
        chk("inv_dig", dig, 16'h5278);
        idle(96);
        chk("to_before", valid, 1);
        idle(1);
        chk("to_fall", valid, 0);
        chk("to_err_hold", err, 1);
        chk("to_dig_hold", dig, 16'h5278);
        scan(tbl[13], tbl[12], tbl[11], tbl[10], {1'b0, 16'hABCD});
        chk("abcd_valid", valid, 1);
        chk("abcd_err", err, 0);
        chk("abcd_dig", dig, 16'hABCD);
        put(0, tbl[9], 8);
        an  = 4'b0011;
        seg = tbl[0];
        repeat (20) @(negedge clk);
        idle(20);
        chk("fault_dig", dig, 16'hABC9);
        chk("fault_frames", frames, 3);
        put(1, tbl[6], 8);
        put(2, tbl[5], 8);
        expect_frame({1'b0, 16'h4569});
        put(3, tbl[4], 8);
        chk("fault_frame", frames, 4);
        chk("fault_after_dig", dig, 16'h4569);
        put(0, tbl[1], 8);
        put(1, tbl[2], 8);
        chk("part_dig", dig, 16'h4521);
        an  = '1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_dig", dig, 0);
        chk("mid_rst_frame", frame, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_valid", valid, 0);
        put(2, tbl[7], 8);
        put(3, tbl[8], 8);
        chk("half_frames", frames, 4);
        chk("half_dig", dig, 16'h8700);
        put(0, tbl[1], 8);
        expect_frame({1'b0, 16'h8721});
        put(1, tbl[2], 8);
        chk("post_rst_frame", frames, 5);
        chk("post_rst_valid", valid, 1);
        put(2, tbl[3], 8);
        put(3, tbl[4], 8);
        chk("one_frame_only", frames, 5);
        chk("final_dig", dig, 16'h4321);
        chk("queue_empty", q.size(), 0);
        chk("frame_count", frames, nexp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
